big7_shift_out: RTL and testbench

- Downstream stage of the big seven-segment expander.
- Takes the four 8-bit LED column bytes (leds1..leds4) and serialises them into an external chain of four 74HC595-style shift registers, driving data, shift clock and latch.
- One transfer per start request; busy/done handshake toward the controller that refreshes the display.

---
 rtl/big7_shift_out.sv | 126 ++++++++++++
 tb/tb_big7_shift_out.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/big7_shift_out.sv
// Serialises four LED column bytes into a chain of 74HC595-style shift registers.
// One 32-bit transfer per start, MSB of leds4 first, followed by one storage-latch pulse.
module big7_shift_out #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] leds1,
    input  logic [7:0] leds2,
    input  logic [7:0] leds3,
    input  logic [7:0] leds4,
    output logic       busy,
    output logic       done,
    output logic       sr_data,
    output logic       sr_clk,
    output logic       sr_latch
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   sr_q, sr_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sr_clk_q, sr_clk_d;
    logic          sr_latch_q, sr_latch_d;
    logic          div_wrap;

    assign div_wrap = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sr_clk_d   = sr_clk_q;
        sr_latch_d = sr_latch_q;
        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                sr_clk_d   = 1'b0;
                sr_latch_d = 1'b0;
                if (start) begin
                    sr_d      = {leds4, leds3, leds2, leds1};
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    sr_clk_d  = 1'b1;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            HIGH: begin
                if (div_wrap) begin
                    // Data advances only with the falling shift clock, keeping hold time at a full phase.
                    div_cnt_d = '0;
                    sr_clk_d  = 1'b0;
                    sr_d      = sr_q << 1;
                    if (bit_cnt_q == 5'd31) begin
                        sr_latch_d = 1'b1;
                        state_d    = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = SETUP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            LATCH: begin
                if (div_wrap) begin
                    div_cnt_d  = '0;
                    sr_latch_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sr_data  = sr_q[31];
    assign sr_clk   = sr_clk_q;
    assign sr_latch = sr_latch_q;
endmodule

// File: tb/tb_big7_shift_out.sv
// Bench for big7_shift_out: three instances (CLK_DIV 1, 2, 5) checked against
// a transfer-level model of the serial waveform, timing and handshake.
module tb_big7_shift_out;
    logic             clk = 1'b0;
    logic             rstn;
    logic [2:0]       start_r;
    logic [2:0][31:0] word_r;
    logic [2:0]       busy_w, done_w, sdat_w, sclk_w, slat_w;
    int               vecs = 0, errs = 0;
    int               divs [3] = '{1, 2, 5};
    int               dq [$];

    always #5 clk = ~clk;

    big7_shift_out #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rstn(rstn), .start(start_r[0]),
        .leds1(word_r[0][7:0]), .leds2(word_r[0][15:8]), .leds3(word_r[0][23:16]), .leds4(word_r[0][31:24]),
        .busy(busy_w[0]), .done(done_w[0]), .sr_data(sdat_w[0]), .sr_clk(sclk_w[0]), .sr_latch(slat_w[0]));
    big7_shift_out #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rstn(rstn), .start(start_r[1]),
        .leds1(word_r[1][7:0]), .leds2(word_r[1][15:8]), .leds3(word_r[1][23:16]), .leds4(word_r[1][31:24]),
        .busy(busy_w[1]), .done(done_w[1]), .sr_data(sdat_w[1]), .sr_clk(sclk_w[1]), .sr_latch(slat_w[1]));
    big7_shift_out #(.CLK_DIV(5)) u_d5 (
        .clk(clk), .rstn(rstn), .start(start_r[2]),
        .leds1(word_r[2][7:0]), .leds2(word_r[2][15:8]), .leds3(word_r[2][23:16]), .leds4(word_r[2][31:24]),
        .busy(busy_w[2]), .done(done_w[2]), .sr_data(sdat_w[2]), .sr_clk(sclk_w[2]), .sr_latch(slat_w[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs(input int k);
        return {busy_w[k], done_w[k], sdat_w[k], sclk_w[k], slat_w[k]};
    endfunction

    // mode 0: plain, 1: leds forced to all-ones after 6 bits, 2: start toggled randomly while busy
    task automatic xfer(input int k, input logic [31:0] w, input int mode);
        int d = divs[k];
        logic [31:0] bits = '0;
        int rises = 0, first_rise = -1, lat_pulses = 0, lat_w = 0;
        int done_at = -1, done_n = 0, busy_n = 0, overlap = 0, bad_w = 0, run = 0;
        logic prev_clk = 1'b0, prev_lat = 1'b0;
        string t = $sformatf("d%0d_m%0d", d, mode);
        @(posedge clk); #1;
        word_r[k]  = w;
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        for (int n = 0; n < 65 * d + 4; n++) begin
            @(negedge clk);
            if (busy_w[k]) busy_n++;
            if (done_w[k]) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
            if (sclk_w[k] && slat_w[k]) overlap++;
            if (slat_w[k]) lat_w++;
            if (slat_w[k] && !prev_lat) lat_pulses++;
            if (sclk_w[k] && !prev_clk) begin
                rises++;
                bits = {bits[30:0], sdat_w[k]};
                if (first_rise < 0) first_rise = n;
                if (rises > 1 && run != d) bad_w++;
                run = 0;
            end else if (!sclk_w[k] && prev_clk) begin
                if (run != d) bad_w++;
                run = 0;
            end
            run++;
            prev_clk = sclk_w[k];
            prev_lat = slat_w[k];
            if (mode == 1 && rises == 6) word_r[k] = '1;
            if (mode == 2) start_r[k] = (n < 60 * d) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk({t, "_word"},     bits, w);
        chk({t, "_rises"},    rises, 32);
        chk({t, "_rise1"},    first_rise, d);
        chk({t, "_widths"},   bad_w, 0);
        chk({t, "_latches"},  lat_pulses, 1);
        chk({t, "_latw"},     lat_w, d);
        chk({t, "_done_at"},  done_at, 65 * d);
        chk({t, "_done_n"},   done_n, 1);
        chk({t, "_busy_n"},   busy_n, 65 * d);
        chk({t, "_overlap"},  overlap, 0);
        chk({t, "_idle_out"}, {27'd0, outs(k)}, 32'd0);
    endtask

    initial begin
        int busy_n, lat_n;
        rstn    = 1'b0;
        start_r = '0;
        word_r  = '0;
        #12;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_out%0d", k), {27'd0, outs(k)}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        xfer(1, 32'hA5187E81, 0);
        xfer(1, 32'hA5187E81, 1);
        xfer(1, $urandom, 2);

        // Start held: second capture lands on the first IDLE edge after done.
        @(posedge clk); #1;
        word_r[1]  = $urandom;
        start_r[1] = 1'b1;
        @(posedge clk);
        dq.delete();
        for (int n = 0; n < 276; n++) begin
            @(negedge clk);
            if (done_w[1]) dq.push_back(n);
            if (n == 131) chk("b2b_busy_again", busy_w[1], 1'b1);
            if (n == 200) start_r[1] = 1'b0;
        end
        chk("b2b_done_cnt", dq.size(), 2);
        chk("b2b_done0", (dq.size() > 0) ? dq[0] : -1, 130);
        chk("b2b_done1", (dq.size() > 1) ? dq[1] : -1, 261);

        // Asynchronous reset partway through a transfer.
        @(posedge clk); #1;
        word_r[1]  = $urandom;
        start_r[1] = 1'b1;
        @(posedge clk); #1;
        start_r[1] = 1'b0;
        repeat (40) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("arst_out", {27'd0, outs(1)}, 32'd0);
        lat_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (slat_w[1] || sclk_w[1] || busy_w[1]) lat_n++;
        end
        rstn   = 1'b1;
        busy_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (slat_w[1] || busy_w[1] || done_w[1]) busy_n++;
        end
        chk("arst_held", lat_n, 0);
        chk("arst_idle", busy_n, 0);
        xfer(1, $urandom, 0);

        xfer(0, 32'h00000001, 0);
        xfer(2, 32'h00000001, 0);
        for (int i = 0; i < 3; i++) xfer(i, $urandom, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
